// File: rtl/noc_output_port_allocator_pkg.sv
// Shared constants and types for the mesh router output-port allocator.
// Covers VC count, credit depth, port indices and VC ownership states.
package noc_output_port_allocator_pkg;

   localparam int NOC_N_REQ        = 5;
   localparam int NOC_VC_NUM       = 2;
   localparam int NOC_CREDIT_DEPTH = 4;

   typedef enum logic [2:0] {
      PORT_EAST  = 3'd0,
      PORT_WEST  = 3'd1,
      PORT_SOUTH = 3'd2,
      PORT_NORTH = 3'd3,
      PORT_LOCAL = 3'd4
   } port_e;

   typedef enum logic {
      VC_IDLE   = 1'b0,
      VC_LOCKED = 1'b1
   } vc_state_e;

   // Index width that stays at least one bit for degenerate sizes.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/noc_output_port_allocator_rr_arbiter.sv
// Combinational round-robin arbiter.
// It picks the lowest request at or above ptr, or wraps to the lowest request overall.
module noc_rr_arbiter
   import noc_output_port_allocator_pkg::*;
#(
   parameter  int N     = 5,
   localparam int PTR_W = clog2_min1(N)
)(
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt
);

   logic [N-1:0] mask;
   logic [N-1:0] masked_req;
   logic [N-1:0] pick;

   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (i >= int'(ptr));
      end
      masked_req = req & mask;
      pick       = (masked_req != '0) ? masked_req : req;
      gnt        = pick & (~pick + N'(1));
   end

endmodule

// File: rtl/noc_output_port_allocator.sv
// Per-output-port switch allocator that shares one outgoing link between the router inputs.
// It holds wormhole VC ownership and downstream credit counts for each VC.
module noc_output_port_allocator
   import noc_output_port_allocator_pkg::*;
#(
   parameter  int N_REQ        = NOC_N_REQ,
   parameter  int VC_NUM       = NOC_VC_NUM,
   parameter  int CREDIT_DEPTH = NOC_CREDIT_DEPTH,
   localparam int VC_W         = clog2_min1(VC_NUM),
   localparam int CNT_W        = $clog2(CREDIT_DEPTH + 1),
   localparam int IDX_W        = clog2_min1(N_REQ)
)(
   input  logic                   noc_clk,
   input  logic                   noc_rst_n,
   input  logic [N_REQ-1:0]       active_mask,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*VC_W-1:0]  req_vc,
   input  logic [N_REQ-1:0]       req_tail,
   input  logic [VC_NUM-1:0]      credit_return,
   output logic [N_REQ-1:0]       grant,
   output logic [VC_W-1:0]        grant_vc,
   output logic [VC_NUM-1:0]      credit_avail,
   output logic [VC_NUM-1:0]      vc_locked,
   output logic                   credit_err
);

   logic [N_REQ-1:0]        eligible;
   logic [N_REQ-1:0]        arb_gnt;
   logic [IDX_W-1:0]        rr_ptr;
   logic [IDX_W-1:0]        gnt_idx;
   logic                    any_gnt;
   logic                    gnt_tail;
   logic [VC_NUM*IDX_W-1:0] vc_owner;
   logic [VC_NUM-1:0]       err_set;

   for (genvar r = 0; r < N_REQ; r++) begin : g_elig
      logic [VC_W-1:0] v;
      assign v = req_vc[r*VC_W +: VC_W];
      assign eligible[r] = req_valid[r] & active_mask[r] & credit_avail[v] &
                           (~vc_locked[v] | (vc_owner[v*IDX_W +: IDX_W] == IDX_W'(r)));
   end

   noc_rr_arbiter #(.N(N_REQ)) u_arb (
      .req (eligible),
      .ptr (rr_ptr),
      .gnt (arb_gnt)
   );

   // Grant is forced low for the whole reset, including mid-cycle assertion.
   assign grant = noc_rst_n ? arb_gnt : '0;

   always_comb begin
      gnt_idx = '0;
      for (int r = 0; r < N_REQ; r++) begin
         if (grant[r]) gnt_idx = IDX_W'(r);
      end
      any_gnt  = |grant;
      gnt_tail = req_tail[gnt_idx];
      grant_vc = any_gnt ? req_vc[gnt_idx*VC_W +: VC_W] : '0;
   end

   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         rr_ptr <= '0;
      end else if (any_gnt) begin
         rr_ptr <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
   end

   for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      logic [CNT_W-1:0] credit;
      vc_state_e        state;
      logic [IDX_W-1:0] owner;
      logic             take;
      logic             ret;

      assign take       = any_gnt && (grant_vc == VC_W'(v));
      assign ret        = credit_return[v];
      assign err_set[v] = ret && !take && (credit == CNT_W'(CREDIT_DEPTH));

      always_ff @(posedge noc_clk or negedge noc_rst_n) begin
         if (!noc_rst_n) begin
            credit <= CNT_W'(CREDIT_DEPTH);
         end else if (take && !ret) begin
            credit <= credit - CNT_W'(1);
         end else if (ret && !take && credit != CNT_W'(CREDIT_DEPTH)) begin
            credit <= credit + CNT_W'(1);
         end
      end

      // A head flit locks the VC to its sender; the tail from the owner frees it.
      always_ff @(posedge noc_clk or negedge noc_rst_n) begin
         if (!noc_rst_n) begin
            state <= VC_IDLE;
            owner <= '0;
         end else if (take) begin
            if (state == VC_IDLE && !gnt_tail) begin
               state <= VC_LOCKED;
               owner <= gnt_idx;
            end else if (state == VC_LOCKED && gnt_tail) begin
               state <= VC_IDLE;
            end
         end
      end

      assign credit_avail[v]              = (credit != '0);
      assign vc_locked[v]                 = (state == VC_LOCKED);
      assign vc_owner[v*IDX_W +: IDX_W]   = owner;
   end

   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         credit_err <= 1'b0;
      end else if (|err_set) begin
         credit_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_noc_output_port_allocator.sv
// Directed bench for the output-port allocator: rotation, credits, wormhole locking,
// VC interleave, credit overflow, input masking and mid-packet reset.
module tb_noc_output_port_allocator;

   logic       noc_clk = 1'b0;
   logic       noc_rst_n;
   logic [4:0] active_mask;
   logic [4:0] req_valid;
   logic [4:0] req_vc;
   logic [4:0] req_tail;
   logic [1:0] credit_return;
   logic [4:0] grant;
   logic       grant_vc;
   logic [1:0] credit_avail;
   logic [1:0] vc_locked;
   logic       credit_err;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 noc_clk = ~noc_clk;

   noc_output_port_allocator dut (
      .noc_clk       (noc_clk),
      .noc_rst_n     (noc_rst_n),
      .active_mask   (active_mask),
      .req_valid     (req_valid),
      .req_vc        (req_vc),
      .req_tail      (req_tail),
      .credit_return (credit_return),
      .grant         (grant),
      .grant_vc      (grant_vc),
      .credit_avail  (credit_avail),
      .vc_locked     (vc_locked),
      .credit_err    (credit_err)
   );

   // A requester must keep its VC for the whole packet.
   logic [4:0] mon_in_pkt;
   logic [4:0] mon_vc;
   always @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         mon_in_pkt <= '0;
         mon_vc     <= '0;
      end else begin
         for (int r = 0; r < 5; r++) begin
            if (grant[r]) begin
               assert (!(mon_in_pkt[r] && (mon_vc[r] != req_vc[r])))
                  else $error("FAIL vc_change input %0d", r);
               mon_in_pkt[r] <= !req_tail[r];
               mon_vc[r]     <= req_vc[r];
            end
         end
      end
   end

   task automatic tick;
      @(posedge noc_clk);
      #1;
   endtask

   task automatic clear_inputs;
      active_mask   = 5'h1f;
      req_valid     = '0;
      req_vc        = '0;
      req_tail      = '0;
      credit_return = '0;
   endtask

   task automatic do_reset;
      clear_inputs();
      noc_rst_n = 1'b0;
      tick();
      tick();
      noc_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      clear_inputs();
      noc_rst_n = 1'b0;
      req_valid = 5'h1f;
      req_tail  = 5'h1f;
      tick();
      tick();
      #2;
      n_checks++;
      if (grant !== 5'b0) $display("FAIL reset_grant: got %b want %b", grant, 5'b0);
      else n_pass++;
      n_checks++;
      if (credit_avail !== 2'b11) $display("FAIL reset_credit_avail: got %b want %b", credit_avail, 2'b11);
      else n_pass++;
      n_checks++;
      if (vc_locked !== 2'b00) $display("FAIL reset_vc_locked: got %b want %b", vc_locked, 2'b00);
      else n_pass++;
      n_checks++;
      if (credit_err !== 1'b0) $display("FAIL reset_credit_err: got %b want %b", credit_err, 1'b0);
      else n_pass++;
      n_checks++;
      if (grant_vc !== 1'b0) $display("FAIL reset_grant_vc: got %b want %b", grant_vc, 1'b0);
      else n_pass++;
   endtask

   task automatic test_rotation;
      logic [4:0] exp;
      do_reset();
      req_valid     = 5'h1f;
      req_tail      = 5'h1f;
      req_vc        = 5'h00;
      credit_return = 2'b01;
      for (int i = 0; i < 6; i++) begin
         exp = 5'b00001 << (i % 5);
         #2;
         n_checks++;
         if (grant !== exp) $display("FAIL rot_grant[%0d]: got %b want %b", i, grant, exp);
         else n_pass++;
         n_checks++;
         if (credit_avail !== 2'b11) $display("FAIL rot_credit_avail[%0d]: got %b want %b", i, credit_avail, 2'b11);
         else n_pass++;
         tick();
      end
      n_checks++;
      if (credit_err !== 1'b0) $display("FAIL rot_credit_err: got %b want %b", credit_err, 1'b0);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_credit_exhaust;
      logic [4:0] exp;
      do_reset();
      req_valid = 5'b00100;
      req_vc    = 5'b00100;
      req_tail  = 5'b00100;
      for (int i = 0; i < 6; i++) begin
         exp = (i < 4) ? 5'b00100 : 5'b00000;
         #2;
         n_checks++;
         if (grant !== exp) $display("FAIL exh_grant[%0d]: got %b want %b", i, grant, exp);
         else n_pass++;
         if (i == 0) begin
            n_checks++;
            if (grant_vc !== 1'b1) $display("FAIL exh_grant_vc: got %b want %b", grant_vc, 1'b1);
            else n_pass++;
         end
         tick();
      end
      n_checks++;
      if (credit_avail !== 2'b01) $display("FAIL exh_credit_avail: got %b want %b", credit_avail, 2'b01);
      else n_pass++;
      credit_return = 2'b10;
      #2;
      n_checks++;
      if (grant !== 5'b0) $display("FAIL exh_ret_cycle_grant: got %b want %b", grant, 5'b0);
      else n_pass++;
      tick();
      credit_return = 2'b00;
      #2;
      n_checks++;
      if (grant !== 5'b00100) $display("FAIL exh_refill_grant: got %b want %b", grant, 5'b00100);
      else n_pass++;
      tick();
      #2;
      n_checks++;
      if (grant !== 5'b0) $display("FAIL exh_after_refill_grant: got %b want %b", grant, 5'b0);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_wormhole;
      do_reset();
      req_valid     = 5'b01010;
      req_vc        = 5'b00000;
      req_tail      = 5'b01000;
      credit_return = 2'b01;
      #2;
      n_checks++;
      if (grant !== 5'b00010) $display("FAIL worm_head_grant: got %b want %b", grant, 5'b00010);
      else n_pass++;
      tick();
      n_checks++;
      if (vc_locked !== 2'b01) $display("FAIL worm_locked_after_head: got %b want %b", vc_locked, 2'b01);
      else n_pass++;
      #2;
      n_checks++;
      if (grant !== 5'b00010) $display("FAIL worm_body_grant: got %b want %b", grant, 5'b00010);
      else n_pass++;
      tick();
      req_tail = 5'b01010;
      #2;
      n_checks++;
      if (grant !== 5'b00010) $display("FAIL worm_tail_grant: got %b want %b", grant, 5'b00010);
      else n_pass++;
      tick();
      n_checks++;
      if (vc_locked !== 2'b00) $display("FAIL worm_unlocked_after_tail: got %b want %b", vc_locked, 2'b00);
      else n_pass++;
      req_valid = 5'b01000;
      #2;
      n_checks++;
      if (grant !== 5'b01000) $display("FAIL worm_waiter_grant: got %b want %b", grant, 5'b01000);
      else n_pass++;
      tick();
      clear_inputs();
   endtask

   task automatic test_interleave;
      logic [4:0] exp_seq [6];
      int sent0;
      int sent4;
      exp_seq = '{5'b00001, 5'b10000, 5'b00001, 5'b10000, 5'b00001, 5'b10000};
      sent0 = 0;
      sent4 = 0;
      do_reset();
      req_vc        = 5'b10000;
      credit_return = 2'b11;
      for (int i = 0; i < 6; i++) begin
         req_valid   = {(sent4 < 3), 3'b000, (sent0 < 3)};
         req_tail    = {(sent4 == 2), 3'b000, (sent0 == 2)};
         #2;
         n_checks++;
         if (grant !== exp_seq[i]) $display("FAIL ilv_grant[%0d]: got %b want %b", i, grant, exp_seq[i]);
         else n_pass++;
         if (exp_seq[i][0]) sent0++;
         if (exp_seq[i][4]) sent4++;
         tick();
         if (i == 1) begin
            n_checks++;
            if (vc_locked !== 2'b11) $display("FAIL ilv_both_locked: got %b want %b", vc_locked, 2'b11);
            else n_pass++;
         end
         if (i == 4) begin
            n_checks++;
            if (vc_locked !== 2'b10) $display("FAIL ilv_vc0_released: got %b want %b", vc_locked, 2'b10);
            else n_pass++;
         end
      end
      n_checks++;
      if (vc_locked !== 2'b00) $display("FAIL ilv_all_released: got %b want %b", vc_locked, 2'b00);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_credit_same_cycle;
      logic [4:0] exp;
      do_reset();
      req_valid = 5'b00001;
      req_tail  = 5'b00001;
      for (int i = 0; i < 6; i++) begin
         credit_return = (i == 2) ? 2'b01 : 2'b00;
         exp = (i < 5) ? 5'b00001 : 5'b00000;
         #2;
         n_checks++;
         if (grant !== exp) $display("FAIL same_grant[%0d]: got %b want %b", i, grant, exp);
         else n_pass++;
         if (i == 5) begin
            n_checks++;
            if (credit_avail !== 2'b10) $display("FAIL same_credit_avail: got %b want %b", credit_avail, 2'b10);
            else n_pass++;
         end
         tick();
      end
      req_valid     = 5'b0;
      credit_return = 2'b01;
      repeat (4) tick();
      n_checks++;
      if (credit_err !== 1'b0) $display("FAIL ovf_err_early: got %b want %b", credit_err, 1'b0);
      else n_pass++;
      n_checks++;
      if (credit_avail !== 2'b11) $display("FAIL ovf_credit_avail: got %b want %b", credit_avail, 2'b11);
      else n_pass++;
      tick();
      credit_return = 2'b00;
      n_checks++;
      if (credit_err !== 1'b1) $display("FAIL ovf_err_set: got %b want %b", credit_err, 1'b1);
      else n_pass++;
      tick();
      tick();
      n_checks++;
      if (credit_err !== 1'b1) $display("FAIL ovf_err_sticky: got %b want %b", credit_err, 1'b1);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_mask_and_reset;
      logic [4:0] exp;
      do_reset();
      active_mask = 5'b11101;
      req_valid   = 5'b00010;
      req_tail    = 5'b00010;
      for (int i = 0; i < 3; i++) begin
         #2;
         n_checks++;
         if (grant !== 5'b0) $display("FAIL mask_grant[%0d]: got %b want %b", i, grant, 5'b0);
         else n_pass++;
         tick();
      end
      active_mask = 5'h1f;
      req_valid   = 5'b00001;
      req_vc      = 5'b00001;
      req_tail    = 5'b00000;
      #2;
      n_checks++;
      if (grant !== 5'b00001 || grant_vc !== 1'b1)
         $display("FAIL mrst_head: got grant %b vc %b want %b vc %b", grant, grant_vc, 5'b00001, 1'b1);
      else n_pass++;
      tick();
      n_checks++;
      if (vc_locked !== 2'b10) $display("FAIL mrst_locked: got %b want %b", vc_locked, 2'b10);
      else n_pass++;
      #2;
      noc_rst_n = 1'b0;
      #1;
      n_checks++;
      if (grant !== 5'b0) $display("FAIL mrst_grant_in_reset: got %b want %b", grant, 5'b0);
      else n_pass++;
      n_checks++;
      if (vc_locked !== 2'b00 || credit_avail !== 2'b11)
         $display("FAIL mrst_state_in_reset: got locked %b avail %b want %b %b", vc_locked, credit_avail, 2'b00, 2'b11);
      else n_pass++;
      tick();
      clear_inputs();
      noc_rst_n = 1'b1;
      tick();
      n_checks++;
      if (vc_locked !== 2'b00) $display("FAIL mrst_locked_after: got %b want %b", vc_locked, 2'b00);
      else n_pass++;
      req_valid = 5'b00001;
      req_vc    = 5'b00001;
      req_tail  = 5'b00001;
      for (int i = 0; i < 5; i++) begin
         exp = (i < 4) ? 5'b00001 : 5'b00000;
         #2;
         n_checks++;
         if (grant !== exp) $display("FAIL mrst_credit_grant[%0d]: got %b want %b", i, grant, exp);
         else n_pass++;
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_credit_exhaust();
      test_wormhole();
      test_interleave();
      test_credit_same_cycle();
      test_mask_and_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
